// File: rtl/mem_port_arbiter_if.sv
// Bundle between the IF/MEM stages, the arbiter and the single shared memory port.
// The arbiter uses the slave modport; the stage/memory side uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              MemRead;
  logic              MemWrite;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              fetch_valid;
  logic [31:0]       fetch_instr;
  logic              data_valid;
  logic [31:0]       data_rdata;
  logic              misalign;
  logic              bus_err;
  logic              stall_if;
  logic              stall_mem;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport slave (
    input  fetch_req, fetch_addr, MemRead, MemWrite, funct3, data_addr, data_wdata,
    input  mem_rdata, mem_ready,
    output fetch_valid, fetch_instr, data_valid, data_rdata, misalign, bus_err,
    output stall_if, stall_mem, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, MemRead, MemWrite, funct3, data_addr, data_wdata,
    output mem_rdata, mem_ready,
    input  fetch_valid, fetch_instr, data_valid, data_rdata, misalign, bus_err,
    input  stall_if, stall_mem, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises MEM-stage loads/stores and IF-stage fetches onto one memory port.
// Data beats fetch at arbitration; an issued access always runs to completion or timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [1:0]        alo_q;
  logic [2:0]        f3_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic              fetch_valid_q, data_valid_q, misalign_q, bus_err_q;
  logic [31:0]       fetch_instr_q, data_rdata_q;
  logic              data_req, data_mis;
  logic              unused_ok;

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   be_of = 4'b0001 << a;
      2'b01:   be_of = a[1] ? 4'b1100 : 4'b0011;
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   wdata_of = {4{w[7:0]}};
      2'b01:   wdata_of = {2{w[15:0]}};
      default: wdata_of = w;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1] && a != 2'b00);
  endfunction

  // Lane select plus extension; reserved encodings fall through as word loads.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'h0, b};
      3'b101:  load_ext = {16'h0, h};
      default: load_ext = w;
    endcase
  endfunction

  assign data_req  = bus.MemRead | bus.MemWrite;
  assign data_mis  = misaligned(bus.funct3, bus.data_addr[1:0]);
  assign cnt_nxt   = cnt + CW'(1);
  assign unused_ok = ^bus.fetch_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      alo_q         <= '0;
      f3_q          <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      fetch_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
      fetch_instr_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      fetch_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req) begin
            alo_q <= bus.data_addr[1:0];
            f3_q  <= bus.funct3;
            if (data_mis) begin
              state        <= RESP;
              data_valid_q <= 1'b1;
              misalign_q   <= 1'b1;
              data_rdata_q <= '0;
            end else begin
              state       <= DATA;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.MemWrite;
              mem_addr_q  <= {bus.data_addr[ADDR_W-1:2], 2'b00};
              mem_be_q    <= be_of(bus.funct3, bus.data_addr[1:0]);
              mem_wdata_q <= wdata_of(bus.funct3, bus.data_wdata);
            end
          end else if (bus.fetch_req) begin
            state       <= FETCH;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {bus.fetch_addr[ADDR_W-1:2], 2'b00};
            mem_be_q    <= 4'b1111;
            mem_wdata_q <= '0;
          end
        end
        DATA, FETCH: begin
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            state     <= RESP;
            if (state == DATA) begin
              data_valid_q <= 1'b1;
              data_rdata_q <= load_ext(bus.mem_rdata, alo_q, f3_q);
            end else begin
              fetch_valid_q <= 1'b1;
              fetch_instr_q <= bus.mem_rdata;
            end
          end else if (cnt_nxt == CW'(TIMEOUT)) begin
            // Give up on the memory: the stage still gets its valid, flagged as an error.
            mem_req_q <= 1'b0;
            state     <= RESP;
            bus_err_q <= 1'b1;
            if (state == DATA) begin
              data_valid_q <= 1'b1;
              data_rdata_q <= '0;
            end else begin
              fetch_valid_q <= 1'b1;
              fetch_instr_q <= '0;
            end
          end else begin
            cnt <= cnt_nxt;
          end
        end
        RESP: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_instr = fetch_instr_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.data_rdata  = data_rdata_q;
  assign bus.misalign    = misalign_q;
  assign bus.bus_err     = bus_err_q;
  assign bus.stall_if    = bus.fetch_req & ~fetch_valid_q;
  assign bus.stall_mem   = data_req & ~data_valid_q;
endmodule
